// File: rtl/sdram_port_arb.sv
// Two-channel, two-class (write/read) arbiter in front of a single SDRAM controller port.
// Writes normally win; a pending read is forced through after STARVE_MAX consecutive write grants.
module sdram_port_arb #(
  parameter logic [15:0] TIMEOUT    = 16'd1023,
  parameter logic [3:0]  STARVE_MAX = 4'd8
) (
  input  logic        clk_ref,
  input  logic        rst_n,

  input  logic        ch0_wr_req,
  input  logic        ch0_rd_req,
  input  logic [23:0] ch0_wr_addr,
  input  logic [23:0] ch0_rd_addr,
  input  logic [9:0]  ch0_wr_len,
  input  logic [9:0]  ch0_rd_len,
  input  logic [15:0] ch0_din,
  output logic        ch0_wr_ack,
  output logic        ch0_rd_ack,
  output logic [15:0] ch0_dout,

  input  logic        ch1_wr_req,
  input  logic        ch1_rd_req,
  input  logic [23:0] ch1_wr_addr,
  input  logic [23:0] ch1_rd_addr,
  input  logic [9:0]  ch1_wr_len,
  input  logic [9:0]  ch1_rd_len,
  input  logic [15:0] ch1_din,
  output logic        ch1_wr_ack,
  output logic        ch1_rd_ack,
  output logic [15:0] ch1_dout,

  output logic        sdram_wr_req,
  output logic        sdram_rd_req,
  output logic [23:0] sdram_wr_addr,
  output logic [23:0] sdram_rd_addr,
  output logic [9:0]  sdram_wr_len,
  output logic [9:0]  sdram_rd_len,
  input  logic        sdram_wr_ack,
  input  logic        sdram_rd_ack,
  output logic [15:0] sdram_din,
  input  logic [15:0] sdram_dout,

  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_err,

  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_starve_cnt
);

  // Controller handshake: sdram_*_req is a registered level held from REQ entry until
  // the matching sdram_*_ack is sampled high; the ack then stays high for the whole burst
  // and its falling edge ends the burst.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        wr_req_q, wr_req_d;
  logic        rd_req_q, rd_req_d;
  logic [23:0] wr_addr_q, wr_addr_d;
  logic [23:0] rd_addr_q, rd_addr_d;
  logic [9:0]  wr_len_q, wr_len_d;
  logic [9:0]  rd_len_q, rd_len_d;
  logic        wr_last_q, wr_last_d;
  logic        rd_last_q, rd_last_d;
  logic [3:0]  starve_q, starve_d;
  logic [15:0] wait_q, wait_d;
  logic        tmo_q, tmo_d;

  logic        any_wr, any_rd;
  logic        wr_pick_ch, rd_pick_ch;
  logic        pick_rd;
  logic        cls_ack;
  logic [16:0] wait_inc;
  logic        wait_expired;
  logic        in_burst;

  always_comb begin : arb_comb
    any_wr     = ch0_wr_req | ch1_wr_req;
    any_rd     = ch0_rd_req | ch1_rd_req;
    // On a tie the channel not most recently served in that class wins.
    wr_pick_ch = (ch0_wr_req && ch1_wr_req) ? ~wr_last_q : ch1_wr_req;
    rd_pick_ch = (ch0_rd_req && ch1_rd_req) ? ~rd_last_q : ch1_rd_req;
    pick_rd    = any_rd && (!any_wr || (starve_q >= STARVE_MAX));
    cls_ack    = grant_q[1] ? sdram_rd_ack : sdram_wr_ack;
    wait_inc   = {1'b0, wait_q} + 17'd1;
    wait_expired = (wait_inc >= {1'b0, TIMEOUT});
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      wr_addr_q <= 24'd0;
      rd_addr_q <= 24'd0;
      wr_len_q  <= 10'd0;
      rd_len_q  <= 10'd0;
      wr_last_q <= 1'b1;
      rd_last_q <= 1'b1;
      starve_q  <= 4'd0;
      wait_q    <= 16'd0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      wr_req_q  <= wr_req_d;
      rd_req_q  <= rd_req_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_len_q  <= wr_len_d;
      rd_len_q  <= rd_len_d;
      wr_last_q <= wr_last_d;
      rd_last_q <= rd_last_d;
      starve_q  <= starve_d;
      wait_q    <= wait_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin : next_state_comb
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_wr || any_rd) state_d = S_REQ;
      S_REQ: begin
        if (cls_ack)           state_d = S_BURST;
        else if (wait_expired) state_d = S_IDLE;
      end
      S_BURST: if (!cls_ack) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : datapath_comb
    grant_d   = grant_q;
    wr_req_d  = wr_req_q;
    rd_req_d  = rd_req_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_len_d  = wr_len_q;
    rd_len_d  = rd_len_q;
    wr_last_d = wr_last_q;
    rd_last_d = rd_last_q;
    starve_d  = starve_q;
    wait_d    = wait_q;
    tmo_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_wr || any_rd) begin
          wait_d = 16'd0;
          if (pick_rd) begin
            grant_d   = {1'b1, rd_pick_ch};
            rd_req_d  = 1'b1;
            rd_addr_d = rd_pick_ch ? ch1_rd_addr : ch0_rd_addr;
            rd_len_d  = rd_pick_ch ? ch1_rd_len  : ch0_rd_len;
          end else begin
            grant_d   = {1'b0, wr_pick_ch};
            wr_req_d  = 1'b1;
            wr_addr_d = wr_pick_ch ? ch1_wr_addr : ch0_wr_addr;
            wr_len_d  = wr_pick_ch ? ch1_wr_len  : ch0_wr_len;
          end
        end
      end
      S_REQ: begin
        if (cls_ack) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
        end else if (wait_expired) begin
          // Abort leaves the round-robin pointers untouched.
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          tmo_d    = 1'b1;
        end else begin
          wait_d = wait_inc[15:0];
        end
      end
      S_BURST: begin
        if (!cls_ack) begin
          if (grant_q[1]) begin
            rd_last_d = grant_q[0];
            starve_d  = 4'd0;
          end else begin
            wr_last_d = grant_q[0];
            if (any_rd && (starve_q != 4'd15)) starve_d = starve_q + 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin : output_comb
    in_burst       = (state_q == S_BURST);
    ch0_wr_ack     = in_burst && (grant_q == 2'b00) && sdram_wr_ack;
    ch1_wr_ack     = in_burst && (grant_q == 2'b01) && sdram_wr_ack;
    ch0_rd_ack     = in_burst && (grant_q == 2'b10) && sdram_rd_ack;
    ch1_rd_ack     = in_burst && (grant_q == 2'b11) && sdram_rd_ack;
    sdram_din      = grant_q[0] ? ch1_din : ch0_din;
    ch0_dout       = sdram_dout;
    ch1_dout       = sdram_dout;
    sdram_wr_req   = wr_req_q;
    sdram_rd_req   = rd_req_q;
    sdram_wr_addr  = wr_addr_q;
    sdram_rd_addr  = rd_addr_q;
    sdram_wr_len   = wr_len_q;
    sdram_rd_len   = rd_len_q;
    grant          = grant_q;
    busy           = (state_q != S_IDLE);
    timeout_err    = tmo_q;
    dbg_state      = state_q;
    dbg_starve_cnt = starve_q;
  end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb: expected grants are queued as requests are raised
// and compared when the arbiter presents a request to the controller.
module tb_sdram_port_arb;

  localparam int W = 36;
  localparam logic [23:0] A0W = 24'h000100, A1W = 24'h200000;
  localparam logic [23:0] A0R = 24'h3000AA, A1R = 24'h440000;
  localparam logic [9:0]  L0W = 10'd512, L1W = 10'd64, L0R = 10'd32, L1R = 10'd8;

  logic        clk_ref, rst_n;
  logic        ch0_wr_req, ch0_rd_req, ch1_wr_req, ch1_rd_req;
  logic [23:0] ch0_wr_addr, ch0_rd_addr, ch1_wr_addr, ch1_rd_addr;
  logic [9:0]  ch0_wr_len, ch0_rd_len, ch1_wr_len, ch1_rd_len;
  logic [15:0] ch0_din, ch1_din;
  logic        ch0_wr_ack, ch0_rd_ack, ch1_wr_ack, ch1_rd_ack;
  logic [15:0] ch0_dout, ch1_dout;
  logic        sdram_wr_req, sdram_rd_req;
  logic [23:0] sdram_wr_addr, sdram_rd_addr;
  logic [9:0]  sdram_wr_len, sdram_rd_len;
  logic        sdram_wr_ack, sdram_rd_ack;
  logic [15:0] sdram_din, sdram_dout;
  logic [1:0]  grant;
  logic        busy, timeout_err;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_starve_cnt;

  logic [W-1:0] exp_q[$];
  logic [1:0]   cur_grant;
  int checks = 0;
  int errors = 0;

  sdram_port_arb #(.TIMEOUT(16'd20), .STARVE_MAX(4'd8)) dut (
    .clk_ref(clk_ref), .rst_n(rst_n),
    .ch0_wr_req(ch0_wr_req), .ch0_rd_req(ch0_rd_req),
    .ch0_wr_addr(ch0_wr_addr), .ch0_rd_addr(ch0_rd_addr),
    .ch0_wr_len(ch0_wr_len), .ch0_rd_len(ch0_rd_len), .ch0_din(ch0_din),
    .ch0_wr_ack(ch0_wr_ack), .ch0_rd_ack(ch0_rd_ack), .ch0_dout(ch0_dout),
    .ch1_wr_req(ch1_wr_req), .ch1_rd_req(ch1_rd_req),
    .ch1_wr_addr(ch1_wr_addr), .ch1_rd_addr(ch1_rd_addr),
    .ch1_wr_len(ch1_wr_len), .ch1_rd_len(ch1_rd_len), .ch1_din(ch1_din),
    .ch1_wr_ack(ch1_wr_ack), .ch1_rd_ack(ch1_rd_ack), .ch1_dout(ch1_dout),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sdram_wr_addr(sdram_wr_addr), .sdram_rd_addr(sdram_rd_addr),
    .sdram_wr_len(sdram_wr_len), .sdram_rd_len(sdram_rd_len),
    .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
    .sdram_din(sdram_din), .sdram_dout(sdram_dout),
    .grant(grant), .busy(busy), .timeout_err(timeout_err),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // Clock and reset
  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for a controller request, then scores it against the queue head.
  task automatic wait_grant(output int lat);
    bit found;
    logic [W-1:0] exp, obs;
    found = 1'b0;
    lat = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk_ref);
      if (sdram_wr_req || sdram_rd_req) begin
        lat = i;
        found = 1'b1;
        break;
      end
    end
    check("grant_seen", {63'd0, found}, 64'd1);
    if (!found) return;
    check("sb_has_entry", {63'd0, exp_q.size() != 0}, 64'd1);
    if (exp_q.size() == 0) return;
    exp = exp_q.pop_front();
    cur_grant = exp[35:34];
    obs = {grant, grant[1] ? sdram_rd_addr : sdram_wr_addr, grant[1] ? sdram_rd_len : sdram_wr_len};
    check("grant_addr_len", 64'(obs), 64'(exp));
    check("req_class", {62'd0, sdram_rd_req, sdram_wr_req}, exp[35] ? 64'd2 : 64'd1);
    check("busy_in_req", {63'd0, busy}, 64'd1);
  endtask

  // Holds the granted class ack for n cycles and checks routing every cycle.
  task automatic run_burst(input int n, input bit wrong_ack, input bit drop_reqs);
    int bad;
    logic [3:0]  exp_acks, obs_acks;
    logic [15:0] exp_din, last_dout;
    bad = 0;
    exp_acks = 4'd1 << cur_grant;
    exp_din  = cur_grant[0] ? ch1_din : ch0_din;
    if (cur_grant[1]) sdram_rd_ack = 1'b1; else sdram_wr_ack = 1'b1;
    last_dout = sdram_dout;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_ref);
      obs_acks = {ch1_rd_ack, ch0_rd_ack, ch1_wr_ack, ch0_wr_ack};
      if (obs_acks !== exp_acks) bad++;
      if (sdram_wr_req || sdram_rd_req) bad++;
      if (dbg_state !== 2'd2) bad++;
      if (sdram_din !== exp_din) bad++;
      if (ch0_dout !== last_dout || ch1_dout !== last_dout) bad++;
      if (wrong_ack && i == 3) begin
        if (cur_grant[1]) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
      end
      if (wrong_ack && i == 4) begin
        if (cur_grant[1]) sdram_wr_ack = 1'b0; else sdram_rd_ack = 1'b0;
      end
      sdram_dout = 16'($urandom_range(0, 65535));
      last_dout = sdram_dout;
    end
    check(wrong_ack ? "burst_routing_wrong_ack" : "burst_routing", 64'(bad), 64'd0);
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    if (drop_reqs) begin
      ch0_wr_req = 1'b0; ch1_wr_req = 1'b0; ch0_rd_req = 1'b0; ch1_rd_req = 1'b0;
    end
    @(negedge clk_ref);
    check("done_state", 64'(dbg_state), 64'd3);
    check("done_acks_low", {60'd0, ch1_rd_ack, ch0_rd_ack, ch1_wr_ack, ch0_wr_ack}, 64'd0);
    @(negedge clk_ref);
    check("idle_after_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int lat, req_cycles, early;
    rst_n = 1'b0;
    ch0_wr_req = 1'b0; ch0_rd_req = 1'b0; ch1_wr_req = 1'b0; ch1_rd_req = 1'b0;
    ch0_wr_addr = A0W; ch1_wr_addr = A1W; ch0_rd_addr = A0R; ch1_rd_addr = A1R;
    ch0_wr_len = L0W; ch1_wr_len = L1W; ch0_rd_len = L0R; ch1_rd_len = L1R;
    ch0_din = 16'hA0A0; ch1_din = 16'h1B1B;
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; sdram_dout = 16'h0000;
    cur_grant = 2'b00;
    repeat (3) @(negedge clk_ref);

    // Reset state
    check("rst_reqs", {62'd0, sdram_rd_req, sdram_wr_req}, 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
    check("rst_addr_len", {sdram_wr_addr, sdram_wr_len, sdram_rd_len}, 64'd0);
    check("rst_starve", 64'(dbg_starve_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk_ref);

    // Single ch0 write; request dropped after grant must not disturb the burst
    exp_q.push_back({2'b00, A0W, L0W});
    ch0_wr_req = 1'b1;
    wait_grant(lat);
    check("wr_req_latency", 64'(lat), 64'd1);
    ch0_wr_req = 1'b0;
    run_burst(512, 1'b0, 1'b0);

    // Reset at burst cycle 100 of a ch1 write
    exp_q.push_back({2'b01, A1W, L1W});
    ch1_wr_req = 1'b1;
    wait_grant(lat);
    sdram_wr_ack = 1'b1;
    repeat (100) @(negedge clk_ref);
    check("pre_reset_ack", {63'd0, ch1_wr_ack}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_acks", {60'd0, ch1_rd_ack, ch0_rd_ack, ch1_wr_ack, ch0_wr_ack}, 64'd0);
    check("mid_rst_reqs", {62'd0, sdram_rd_req, sdram_wr_req}, 64'd0);
    check("mid_rst_grant_busy", {61'd0, grant, busy}, 64'd0);
    check("mid_rst_addr_len", {sdram_wr_addr, sdram_wr_len}, 64'd0);
    sdram_wr_ack = 1'b0;
    ch1_wr_req = 1'b0;
    @(negedge clk_ref);
    rst_n = 1'b1;
    @(negedge clk_ref);

    // Write contention alternates from ch0; wrong-class ack injected on the ch1 grant
    exp_q.push_back({2'b00, A0W, L0W});
    exp_q.push_back({2'b01, A1W, L1W});
    exp_q.push_back({2'b00, A0W, L0W});
    ch0_wr_req = 1'b1; ch1_wr_req = 1'b1;
    wait_grant(lat); run_burst(6, 1'b0, 1'b0);
    wait_grant(lat); run_burst(6, 1'b1, 1'b0);
    wait_grant(lat); run_burst(6, 1'b0, 1'b1);

    // Starvation: eight writes then the pending ch0 read is forced
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) exp_q.push_back({2'b01, A1W, L1W});
      else            exp_q.push_back({2'b00, A0W, L0W});
    end
    exp_q.push_back({2'b10, A0R, L0R});
    ch0_wr_req = 1'b1; ch1_wr_req = 1'b1; ch0_rd_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_grant(lat); run_burst(4, 1'b0, 1'b0);
    end
    wait_grant(lat);
    check("starve_at_forced_read", 64'(dbg_starve_cnt), 64'd8);
    run_burst(4, 1'b0, 1'b1);
    check("starve_cleared", 64'(dbg_starve_cnt), 64'd0);

    // Timeout on a ch1 write that is never acked
    exp_q.push_back({2'b01, A1W, L1W});
    ch1_wr_req = 1'b1;
    wait_grant(lat);
    req_cycles = 1;
    early = 0;
    for (int i = 0; i < 40; i++) begin
      if (timeout_err) early++;
      @(negedge clk_ref);
      if (!sdram_wr_req) break;
      req_cycles++;
    end
    check("timeout_req_cycles", 64'(req_cycles), 64'd20);
    check("timeout_no_early_pulse", 64'(early), 64'd0);
    check("timeout_pulse", {62'd0, timeout_err, busy}, 64'd2);
    ch1_wr_req = 1'b0;
    @(negedge clk_ref);
    check("timeout_one_cycle", {63'd0, timeout_err}, 64'd0);

    // Pointer untouched by the abort: ch1 still wins the next write tie
    exp_q.push_back({2'b01, A1W, L1W});
    ch0_wr_req = 1'b1; ch1_wr_req = 1'b1;
    wait_grant(lat); run_burst(3, 1'b0, 1'b1);

    // Lone ch1 read
    exp_q.push_back({2'b11, A1R, L1R});
    ch1_rd_req = 1'b1;
    wait_grant(lat); run_burst(5, 1'b0, 1'b1);

    // Final report
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
